// File: rtl/prog_reload_counter_pkg.sv
// Shared types and constants for the programmable reload counter.
// Holds the state encoding and the count-direction encoding.
package prog_reload_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/prog_reload_counter_tick_prescaler.sv
// Clock prescaler: raises tick once every presc+1 enabled cycles.
// A '>=' compare lets a lowered presc take effect at once instead of hanging.
module tick_prescaler #(
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] pcnt;

   assign tick = en && (pcnt >= presc);

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt <= '0;
      end else if (clr) begin
         pcnt <= '0;
      end else if (en) begin
         if (tick) pcnt <= '0;
         else      pcnt <= pcnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/prog_reload_counter.sv
// Programmable timer/counter: up/down, prescaled, auto-reload or one-shot,
// with a one-cycle terminal-count pulse and a sticky terminal flag.
module prog_reload_counter
   import prog_reload_counter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld,
   input  logic [WIDTH-1:0]   ld_value,
   input  logic               start,
   input  logic               stop,
   input  logic               up,
   input  logic               one_shot,
   input  logic [PRESC_W-1:0] presc,
   input  logic               tc_clr,
   output logic [WIDTH-1:0]   dout,
   output logic               tc_pulse,
   output logic               tc_flag,
   output logic               busy
);

   state_t           state, state_n;
   logic [WIDTH-1:0] reload, reload_n, dout_n, terminal;
   logic             tc_n, tc_flag_n;
   logic             running, tick, presc_clr;

   assign running   = (state == ST_RUN);
   assign terminal  = {WIDTH{up == DIR_UP}};
   // Any command that (re)enters or leaves RUN restarts the prescale phase.
   assign presc_clr = ld || (stop && running) || (start && !running);

   tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk   (clk),
      .rst   (rst),
      .clr   (presc_clr),
      .en    (running),
      .presc (presc),
      .tick  (tick)
   );

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_n  = state;
      dout_n   = dout;
      reload_n = reload;
      tc_n     = 1'b0;
      if (ld) begin
         dout_n   = ld_value;
         reload_n = ld_value;
         state_n  = ST_IDLE;
      end else if (stop) begin
         if (running) state_n = ST_IDLE;
      end else if (start && !running) begin
         state_n = ST_RUN;
         if (state == ST_DONE) dout_n = reload;
      end else if (running && tick) begin
         if (dout == terminal) begin
            tc_n = 1'b1;
            if (one_shot) state_n = ST_DONE;
            else          dout_n  = reload;
         end else if (up == DIR_UP) begin
            dout_n = dout + WIDTH'(1);
         end else begin
            dout_n = dout - WIDTH'(1);
         end
      end
      // A terminal event in the same cycle as tc_clr keeps the flag set.
      tc_flag_n = tc_n || (tc_flag && !tc_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         dout     <= '0;
         reload   <= '0;
         tc_pulse <= 1'b0;
         tc_flag  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         dout     <= dout_n;
         reload   <= reload_n;
         tc_pulse <= tc_n;
         tc_flag  <= tc_flag_n;
         busy     <= (state_n == ST_RUN);
      end
   end

endmodule

// File: tb/tb_prog_reload_counter.sv
// Directed self-checking bench for prog_reload_counter (WIDTH=8, PRESC_W=4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_prog_reload_counter;

   localparam int WIDTH   = 8;
   localparam int PRESC_W = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               ld;
   logic [WIDTH-1:0]   ld_value;
   logic               start;
   logic               stop;
   logic               up;
   logic               one_shot;
   logic [PRESC_W-1:0] presc;
   logic               tc_clr;
   logic [WIDTH-1:0]   dout;
   logic               tc_pulse;
   logic               tc_flag;
   logic               busy;

   int passed = 0;
   int total  = 0;

   prog_reload_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld),
      .ld_value (ld_value),
      .start    (start),
      .stop     (stop),
      .up       (up),
      .one_shot (one_shot),
      .presc    (presc),
      .tc_clr   (tc_clr),
      .dout     (dout),
      .tc_pulse (tc_pulse),
      .tc_flag  (tc_flag),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [WIDTH-1:0] v);
      ld = 1'b1; ld_value = v;
      step();
      ld = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ld = 1'b0; ld_value = '0; start = 1'b0; stop = 1'b0;
      up = 1'b0; one_shot = 1'b0; presc = '0; tc_clr = 1'b0;
      #12;
      total++;
      if ({dout, tc_pulse, tc_flag, busy} !== {8'h00, 3'b000}) begin
         $display("FAIL reset: dout=%h pulse=%b flag=%b busy=%b, want 00 0 0 0",
                  dout, tc_pulse, tc_flag, busy);
      end else passed++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_periodic_down();
      logic [WIDTH-1:0] exp_d [8] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0};
      logic             exp_p [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
      logic             exp_f [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
      up = 1'b0; one_shot = 1'b0; presc = 4'd0;
      load(8'd3);
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         total++;
         if ({dout, tc_pulse, tc_flag, busy} !== {exp_d[i], exp_p[i], exp_f[i], 1'b1}) begin
            $display("FAIL periodic_down[%0d]: dout=%h pulse=%b flag=%b busy=%b, want %h %b %b 1",
                     i, dout, tc_pulse, tc_flag, busy, exp_d[i], exp_p[i], exp_f[i]);
         end else passed++;
         step();
      end
   endtask

   task automatic test_one_shot_presc();
      logic [WIDTH-1:0] exp_d;
      up = 1'b0; one_shot = 1'b1; presc = 4'd2;
      load(8'd2);
      pulse_start();
      for (int i = 0; i < 9; i++) begin
         exp_d = 8'(2 - i / 3);
         total++;
         if ({dout, tc_pulse, busy} !== {exp_d, 1'b0, 1'b1}) begin
            $display("FAIL one_shot_step[%0d]: dout=%h pulse=%b busy=%b, want %h 0 1",
                     i, dout, tc_pulse, busy, exp_d);
         end else passed++;
         step();
      end
      total++;
      if ({dout, tc_pulse, busy} !== {8'h00, 1'b1, 1'b0}) begin
         $display("FAIL one_shot_done: dout=%h pulse=%b busy=%b, want 00 1 0", dout, tc_pulse, busy);
      end else passed++;
      step();
      total++;
      if ({dout, tc_pulse, busy} !== {8'h00, 1'b0, 1'b0}) begin
         $display("FAIL one_shot_held: dout=%h pulse=%b busy=%b, want 00 0 0", dout, tc_pulse, busy);
      end else passed++;
      pulse_start();
      total++;
      if ({dout, busy} !== {8'h02, 1'b1}) begin
         $display("FAIL one_shot_restart: dout=%h busy=%b, want 02 1", dout, busy);
      end else passed++;
   endtask

   task automatic test_periodic_up();
      logic [WIDTH-1:0] exp_d [6] = '{8'hFD, 8'hFE, 8'hFF, 8'hFD, 8'hFE, 8'hFF};
      logic             exp_p [6] = '{0, 0, 0, 1, 0, 0};
      up = 1'b1; one_shot = 1'b0; presc = 4'd0;
      load(8'hFD);
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         total++;
         if ({dout, tc_pulse} !== {exp_d[i], exp_p[i]}) begin
            $display("FAIL periodic_up[%0d]: dout=%h pulse=%b, want %h %b",
                     i, dout, tc_pulse, exp_d[i], exp_p[i]);
         end else passed++;
         step();
      end
      total++;
      if ({dout, tc_pulse} !== {8'hFD, 1'b1}) begin
         $display("FAIL periodic_up_wrap2: dout=%h pulse=%b, want fd 1", dout, tc_pulse);
      end else passed++;
   endtask

   task automatic test_stop_resume_load();
      up = 1'b0; one_shot = 1'b0; presc = 4'd0;
      load(8'd10);
      pulse_start();
      for (int i = 0; i < 4; i++) step();
      total++;
      if (dout !== 8'd6) begin
         $display("FAIL stop_pre: dout=%h, want 06", dout);
      end else passed++;
      stop = 1'b1;
      step();
      stop = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({dout, busy} !== {8'd6, 1'b0}) begin
            $display("FAIL stop_hold[%0d]: dout=%h busy=%b, want 06 0", i, dout, busy);
         end else passed++;
         step();
      end
      pulse_start();
      step();
      total++;
      if ({dout, busy} !== {8'd5, 1'b1}) begin
         $display("FAIL resume_5: dout=%h busy=%b, want 05 1", dout, busy);
      end else passed++;
      step();
      total++;
      if (dout !== 8'd4) begin
         $display("FAIL resume_4: dout=%h, want 04", dout);
      end else passed++;
      load(8'h20);
      total++;
      if ({dout, busy, tc_pulse} !== {8'h20, 1'b0, 1'b0}) begin
         $display("FAIL load_in_run: dout=%h busy=%b pulse=%b, want 20 0 0", dout, busy, tc_pulse);
      end else passed++;
   endtask

   task automatic test_async_reset();
      up = 1'b0; one_shot = 1'b0; presc = 4'd0;
      load(8'd10);
      pulse_start();
      for (int i = 0; i < 3; i++) step();
      total++;
      if ({dout, tc_flag} !== {8'd7, 1'b1}) begin
         $display("FAIL arst_pre: dout=%h flag=%b, want 07 1", dout, tc_flag);
      end else passed++;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({dout, busy, tc_flag, tc_pulse} !== {8'h00, 3'b000}) begin
         $display("FAIL arst_immediate: dout=%h busy=%b flag=%b pulse=%b, want 00 0 0 0",
                  dout, busy, tc_flag, tc_pulse);
      end else passed++;
      #3 rst = 1'b0;
      step();
      pulse_start();
      total++;
      if ({dout, busy, tc_pulse} !== {8'h00, 1'b1, 1'b0}) begin
         $display("FAIL arst_start: dout=%h busy=%b pulse=%b, want 00 1 0", dout, busy, tc_pulse);
      end else passed++;
      step();
      total++;
      if ({dout, tc_pulse, tc_flag, busy} !== {8'h00, 3'b111}) begin
         $display("FAIL arst_first_tick: dout=%h pulse=%b flag=%b busy=%b, want 00 1 1 1",
                  dout, tc_pulse, tc_flag, busy);
      end else passed++;
   endtask

   task automatic test_tc_clr_collision();
      up = 1'b0; one_shot = 1'b0; presc = 4'd0;
      tc_clr = 1'b1;
      load(8'd1);
      tc_clr = 1'b0;
      total++;
      if (tc_flag !== 1'b0) begin
         $display("FAIL clr_alone_pre: flag=%b, want 0", tc_flag);
      end else passed++;
      pulse_start();
      step();
      total++;
      if (dout !== 8'd0) begin
         $display("FAIL clr_at_zero: dout=%h, want 00", dout);
      end else passed++;
      tc_clr = 1'b1;
      step();
      total++;
      if ({tc_flag, tc_pulse, dout} !== {1'b1, 1'b1, 8'd1}) begin
         $display("FAIL clr_vs_set: flag=%b pulse=%b dout=%h, want 1 1 01", tc_flag, tc_pulse, dout);
      end else passed++;
      step();
      tc_clr = 1'b0;
      total++;
      if ({tc_flag, tc_pulse} !== {1'b0, 1'b0}) begin
         $display("FAIL clr_after: flag=%b pulse=%b, want 0 0", tc_flag, tc_pulse);
      end else passed++;
   endtask

   initial begin
      test_reset();
      test_periodic_down();
      test_one_shot_presc();
      test_periodic_up();
      test_stop_resume_load();
      test_async_reset();
      test_tc_clr_collision();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
